// File: rtl/multiword_arith_sequencer_pkg.sv
// Shared definitions for the multi-word arithmetic sequencer: op codes and FSM states.
package multiword_arith_sequencer_pkg;

   localparam logic [2:0] OP_TFR = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_ADC = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_CMP = 3'b100;
   localparam logic [2:0] OP_INC = 3'b101;
   localparam logic [2:0] OP_DEC = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/multiword_arith_sequencer_if.sv
// Start/busy/done handshake and operand/result bus between controller and sequencer.
interface multiword_arith_sequencer_if #(
   parameter int DATA_SIZE    = 8,
   parameter int WORDS        = 4,
   parameter int OP_CODE_SIZE = 3
);

   localparam int W = DATA_SIZE * WORDS;

   logic                    start;
   logic [OP_CODE_SIZE-1:0] op_code;
   logic [W-1:0]            a_in;
   logic [W-1:0]            b_in;
   logic                    carry_in;
   logic                    busy;
   logic                    done;
   logic [W-1:0]            result_out;
   logic                    carry_out;
   logic                    zero_out;

   modport master (
      output start, op_code, a_in, b_in, carry_in,
      input  busy, done, result_out, carry_out, zero_out
   );

   modport slave (
      input  start, op_code, a_in, b_in, carry_in,
      output busy, done, result_out, carry_out, zero_out
   );

endinterface

// File: rtl/mas_slice_adder.sv
// One DATA_SIZE-bit slice of a + b' + cin; b' and the slice-0 carry are chosen from the op code.
module mas_slice_adder
   import multiword_arith_sequencer_pkg::*;
#(
   parameter int DATA_SIZE = 8
) (
   input  logic [2:0]           op,
   input  logic                 first,
   input  logic                 chain_carry,
   input  logic                 ext_carry,
   input  logic [DATA_SIZE-1:0] a,
   input  logic [DATA_SIZE-1:0] b,
   output logic [DATA_SIZE-1:0] sum,
   output logic                 cout
);

   logic [DATA_SIZE-1:0] b_eff;
   logic                 cin;

   // Only the lowest slice takes its carry from the op; higher slices chain the previous carry.
   always_comb begin
      b_eff = '0;
      cin   = chain_carry;
      case (op)
         OP_ADD, OP_ADC:         b_eff = b;
         OP_SUB, OP_CMP:         b_eff = ~b;
         OP_DEC:                 b_eff = '1;
         OP_TFR, OP_INC, OP_RSV: b_eff = '0;
         default:                b_eff = '0;
      endcase
      if (first) begin
         case (op)
            OP_ADC:                 cin = ext_carry;
            OP_SUB, OP_CMP, OP_INC: cin = 1'b1;
            default:                cin = 1'b0;
         endcase
      end
   end

   assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + (DATA_SIZE + 1)'(cin);

endmodule

// File: rtl/multiword_arith_sequencer.sv
// Runs one W-bit operation as WORDS slice ops through a shared slice adder, LSB slice first.
module multiword_arith_sequencer
   import multiword_arith_sequencer_pkg::*;
#(
   parameter int DATA_SIZE    = 8,
   parameter int WORDS        = 4,
   parameter int OP_CODE_SIZE = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   multiword_arith_sequencer_if.slave  bus
);

   localparam int W     = DATA_SIZE * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_t                  state;
   state_t                  next_state;
   logic [IDX_W-1:0]        idx;
   logic [W-1:0]            a_sh;
   logic [W-1:0]            b_sh;
   logic [W-1:0]            sum_sh;
   logic [W-1:0]            full_sum;
   logic [OP_CODE_SIZE-1:0] op_reg;
   logic                    ext_carry;
   logic                    carry_reg;
   logic [DATA_SIZE-1:0]    slice_sum;
   logic                    slice_cout;
   logic                    load;
   logic                    step;
   logic                    last;
   logic [W-1:0]            result_q;
   logic                    carry_q;
   logic                    zero_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = RUN;
         RUN:     if (idx == LAST_IDX) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      load     = (state == IDLE) && bus.start;
      step     = (state == RUN);
      last     = step && (idx == LAST_IDX);
      bus.busy = (state != IDLE);
      bus.done = (state == DONE);
   end

   mas_slice_adder #(.DATA_SIZE(DATA_SIZE)) u_slice (
      .op          (op_reg[2:0]),
      .first       (idx == '0),
      .chain_carry (carry_reg),
      .ext_carry   (ext_carry),
      .a           (a_sh[DATA_SIZE-1:0]),
      .b           (b_sh[DATA_SIZE-1:0]),
      .sum         (slice_sum),
      .cout        (slice_cout)
   );

   // Operands shift down one slice per step; sums shift in from the top so slice 0 ends at the LSB.
   assign full_sum = {slice_sum, sum_sh[W-1:DATA_SIZE]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh      <= '0;
         b_sh      <= '0;
         sum_sh    <= '0;
         op_reg    <= '0;
         ext_carry <= 1'b0;
         carry_reg <= 1'b0;
         idx       <= '0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
      end else if (load) begin
         a_sh      <= bus.a_in;
         b_sh      <= bus.b_in;
         sum_sh    <= '0;
         op_reg    <= bus.op_code;
         ext_carry <= bus.carry_in;
         carry_reg <= 1'b0;
         idx       <= '0;
      end else if (step) begin
         a_sh      <= a_sh >> DATA_SIZE;
         b_sh      <= b_sh >> DATA_SIZE;
         sum_sh    <= full_sum;
         carry_reg <= slice_cout;
         idx       <= idx + 1'b1;
         // Compare reports flags only; the previous result stays visible.
         if (last) begin
            carry_q <= slice_cout;
            zero_q  <= (full_sum == '0);
            if (op_reg[2:0] != OP_CMP) result_q <= full_sum;
         end
      end
   end

   assign bus.result_out = result_q;
   assign bus.carry_out  = carry_q;
   assign bus.zero_out   = zero_q;

endmodule

// File: tb/tb_multiword_arith_sequencer.sv
// Directed self-checking bench for multiword_arith_sequencer with 8-bit slices and 4 words.
module tb_multiword_arith_sequencer;
   import multiword_arith_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   passed = 0;
   int   total  = 0;
   int   lat;
   logic saw_done;

   always #5 clk = ~clk;

   multiword_arith_sequencer_if #(.DATA_SIZE(8), .WORDS(4), .OP_CODE_SIZE(3)) bus ();

   multiword_arith_sequencer #(.DATA_SIZE(8), .WORDS(4), .OP_CODE_SIZE(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
   endtask

   // Called on a negedge; start is seen by the next posedge and dropped at the following negedge.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin);
      bus.op_code  = op;
      bus.a_in     = a;
      bus.b_in     = b;
      bus.carry_in = cin;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
   endtask

   task automatic waitDone(output int cycles);
      cycles = 1;
      while (!bus.done && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [31:0] exp_res, input logic exp_c, input logic exp_z);
      int cycles;
      applyStimulus(op, a, b, cin);
      waitDone(cycles);
      checkOutput({tag, "_latency"}, 32'(cycles), 32'd5);
      checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
      checkOutput({tag, "_result"}, bus.result_out, exp_res);
      checkOutput({tag, "_carry"}, 32'(bus.carry_out), 32'(exp_c));
      checkOutput({tag, "_zero"}, 32'(bus.zero_out), 32'(exp_z));
      @(negedge clk);
      checkOutput({tag, "_done_pulse_end"}, 32'(bus.done), 32'd0);
      checkOutput({tag, "_result_held"}, bus.result_out, exp_res);
   endtask

   initial begin
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.op_code  = '0;
      bus.a_in     = '0;
      bus.b_in     = '0;
      bus.carry_in = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_done", 32'(bus.done), 32'd0);
      checkOutput("reset_result", bus.result_out, 32'd0);
      checkOutput("reset_carry", 32'(bus.carry_out), 32'd0);
      checkOutput("reset_zero", 32'(bus.zero_out), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      runOp("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      runOp("adc",      OP_ADC, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
      runOp("sub_wrap", OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      runOp("dec",      OP_DEC, 32'h0001_0000, 32'h0000_0000, 1'b0, 32'h0000_FFFF, 1'b1, 1'b0);
      runOp("inc",      OP_INC, 32'h00FF_FFFF, 32'h0000_0000, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
      runOp("add",      OP_ADD, 32'h1234_0000, 32'h0000_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
      runOp("cmp_eq",   OP_CMP, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h1234_5678, 1'b1, 1'b1);
      runOp("cmp_lt",   OP_CMP, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
      runOp("tfr",      OP_TFR, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      runOp("rsv",      OP_RSV, 32'h0000_0000, 32'h0000_0123, 1'b1, 32'h0000_0000, 1'b0, 1'b1);

      $display("[TB] start held high through a whole operation");
      bus.op_code  = OP_ADD;
      bus.a_in     = 32'h0000_0001;
      bus.b_in     = 32'h0000_0001;
      bus.carry_in = 1'b0;
      bus.start    = 1'b1;
      @(negedge clk);
      checkOutput("b2b_busy_after_accept", 32'(bus.busy), 32'd1);
      bus.a_in = 32'h0000_0100;
      bus.b_in = 32'h0000_0100;
      waitDone(lat);
      checkOutput("b2b_first_latency", 32'(lat), 32'd5);
      checkOutput("b2b_first_result", bus.result_out, 32'h0000_0002);
      @(negedge clk);
      checkOutput("b2b_idle_busy", 32'(bus.busy), 32'd0);
      checkOutput("b2b_idle_result", bus.result_out, 32'h0000_0002);
      @(negedge clk);
      checkOutput("b2b_second_accept", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      waitDone(lat);
      checkOutput("b2b_second_latency", 32'(lat), 32'd5);
      checkOutput("b2b_second_result", bus.result_out, 32'h0000_0200);
      @(negedge clk);

      $display("[TB] reset in the middle of an operation");
      applyStimulus(OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
      checkOutput("midrst_done", 32'(bus.done), 32'd0);
      checkOutput("midrst_result", bus.result_out, 32'd0);
      checkOutput("midrst_carry", 32'(bus.carry_out), 32'd0);
      checkOutput("midrst_zero", 32'(bus.zero_out), 32'd0);
      @(negedge clk);
      reset    = 1'b0;
      saw_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) saw_done = 1'b1;
      end
      checkOutput("midrst_no_done", 32'(saw_done), 32'd0);
      runOp("post_rst_add", OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
